spike_threshold_unit: RTL
=========================

SPIKE_THRESHOLD_UNIT -- requirements
Module: spike_threshold_unit

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30, number of neurons served (time-multiplexed).
REQ-002 SHALL have parameter THRESHOLD, default 32'h41A00000 (20.0), IEEE-754 fp32 firing threshold.
REQ-003 SHALL have parameter RESET_POTENTIAL, default 32'h00000000, fp32 potential written back after a spike or during refractory.
REQ-004 SHALL have parameter REFRACTORY_STEPS, default 2, timesteps a neuron is held after firing (0 disables refractory).
REQ-005 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-006 Ports, in this order: clk in 1 clock; rst_n in 1 async active-low reset; in_valid in 1 potential available; in_ready out 1 unit can accept; in_potential in 32 decayed fp32 potential; in_neuron_id in 12 neuron address; timestep_tick in 1 one-cycle timestep strobe; out_valid out 1 result available; out_ready in 1 consumer accepts; out_potential out 32 fp32 potential for write-back; out_neuron_id out 12 address; out_spike out 1 neuron fired; out_addr_err out 1 address out of range; spike_total out 16 spike count.

Function
REQ-007 SHALL implement FSM IDLE -> COMPARE -> EMIT -> IDLE; in_ready = 1 only in IDLE.
REQ-008 In IDLE, in_valid & in_ready SHALL register in_potential and in_neuron_id and go to COMPARE.
REQ-009 COMPARE SHALL last exactly one cycle, computing spike and result, then go to EMIT; out_valid SHALL rise 2 cycles after the accept edge.
REQ-010 In EMIT, out_valid = 1 and all out_* SHALL hold stable until out_ready = 1; EMIT & out_ready SHALL return to IDLE next cycle (no back-to-back accept on the same edge).
REQ-011 Spike condition: potential strictly greater than THRESHOLD, using IEEE-754 sign-magnitude ordering; +0 equals -0; NaN never fires; +Inf fires.
REQ-012 On a spike: out_spike = 1, out_potential = RESET_POTENTIAL, the neuron's refractory counter SHALL load REFRACTORY_STEPS.
REQ-013 Non-spike, counter zero: out_spike = 0, out_potential = registered input unchanged (bit-exact, including NaN).
REQ-014 Neuron with refractory counter > 0: out_spike = 0, out_potential = RESET_POTENTIAL regardless of input.
REQ-015 timestep_tick SHALL decrement every non-zero refractory counter by 1 (floor at 0), in any state.
REQ-016 Same-cycle tick and spike load on one neuron: the load SHALL win (counter = REFRACTORY_STEPS).
REQ-017 in_neuron_id >= NUM_NEURONS: out_addr_err = 1, out_spike = 0, out_potential = input unchanged, no counter touched.
REQ-018 Refractory counters SHALL be ceil(log2(REFRACTORY_STEPS+1)) bits (minimum 1), one per neuron.

Reset
REQ-019 rst_n low SHALL asynchronously force state IDLE, all refractory counters 0, out_valid 0, out_spike 0, out_addr_err 0, out_potential 0, out_neuron_id 0, spike_total 0; in_ready = 1 on the first cycle after release.
REQ-020 Reset mid-transaction SHALL discard the in-flight potential; no partial output is emitted.

Configuration
REQ-021 Macro SPIKE_TOTAL_COUNT_EN defined: spike_total SHALL increment by 1 on each EMIT & out_ready with out_spike = 1, saturating at 16'hFFFF.
REQ-022 Macro SPIKE_TOTAL_COUNT_EN undefined: no counter logic; spike_total SHALL be constant 0.

Structure
REQ-023 Shared package neuron_pkg SHALL hold: FP32 width 32, NEURON_ID_W = 12, FP32 field positions (sign 31, exponent 30:23, mantissa 22:0), FSM state typedef (IDLE, COMPARE, EMIT).
REQ-024 fp32 ordering SHALL be a separate combinational sub-module fp32_gt_compare (a, b -> a_gt_b, is_nan).

Verification
REQ-025 Fire: THRESHOLD default, in 32'h41DED852 id 3 -> out_valid 2 cycles later, out_spike 1, out_potential 32'h00000000, out_neuron_id 3.
REQ-026 No fire / sign: in 32'h41800000 (16.0) -> spike 0, potential 32'h41800000; in 32'hC1F00000 (-30.0) -> spike 0, passthrough; in 32'h41A00000 (equal) -> spike 0.
REQ-027 Refractory: fire id 5, resend 32'h41DED852 to id 5 with no tick -> spike 0, potential 0; pulse tick twice, resend -> spike 1; tick coincident with the COMPARE of a firing id 5 -> counter = 2.
REQ-028 Backpressure: hold out_ready 0 for 5 cycles in EMIT -> outputs stable, in_ready 0 throughout; out_ready 1 -> in_ready 1 next cycle.
REQ-029 Errors/NaN: id 30 -> out_addr_err 1, spike 0; in 32'h7FC00000 -> spike 0, passthrough; 32'h7F800000 -> spike 1.
REQ-030 Reset/config: assert rst_n in COMPARE -> out_valid 0 immediately, counters 0; with SPIKE_TOTAL_COUNT_EN, 3 spikes -> spike_total 3; without, spike_total 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the spike threshold datapath: fp32 field layout,
// neuron address width and the threshold FSM state encoding.
// No logic; purely types and constants.
package neuron_pkg;

   localparam int FP32_W      = 32;
   localparam int NEURON_ID_W = 12;

   // IEEE-754 single-precision field positions
   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;
   localparam int MAN_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      EMIT    = 2'd2
   } thr_state_t;

endpackage

// File: rtl/fp32_gt_compare.sv
// Purpose: combinational IEEE-754 fp32 "a strictly greater than b" test.
// Latency: 0 cycles (pure combinational).
// Backpressure: none (no handshake).
// Ports: a, b   - fp32 operands
//        a_gt_b - 1 when a > b; forced 0 if either operand is NaN; +0 == -0
//        is_nan - 1 when either operand is NaN
module fp32_gt_compare
   import neuron_pkg::*;
(
   input  logic [FP32_W-1:0] a,
   input  logic [FP32_W-1:0] b,
   output logic              a_gt_b,
   output logic              is_nan
);

   logic a_nan, b_nan, a_zero, b_zero;

   assign a_nan  = (&a[EXP_MSB:EXP_LSB]) && (|a[MAN_MSB:MAN_LSB]);
   assign b_nan  = (&b[EXP_MSB:EXP_LSB]) && (|b[MAN_MSB:MAN_LSB]);
   assign a_zero = (a[EXP_MSB:MAN_LSB] == '0);
   assign b_zero = (b[EXP_MSB:MAN_LSB] == '0);
   assign is_nan = a_nan || b_nan;

   // Sign-magnitude ordering: with equal signs compare magnitudes (reversed
   // when negative); with different signs the positive one is larger unless
   // both are zeros of opposite sign, which are equal.
   always_comb begin
      a_gt_b = 1'b0;
      if (is_nan || (a_zero && b_zero)) begin
         a_gt_b = 1'b0;
      end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
         a_gt_b = !a[SIGN_BIT];
      end else if (!a[SIGN_BIT]) begin
         a_gt_b = (a[EXP_MSB:MAN_LSB] > b[EXP_MSB:MAN_LSB]);
      end else begin
         a_gt_b = (a[EXP_MSB:MAN_LSB] < b[EXP_MSB:MAN_LSB]);
      end
   end

endmodule

// File: rtl/spike_threshold_unit.sv
// Purpose: time-multiplexed fp32 spike threshold with per-neuron refractory
//          counters; optional saturating spike counter (SPIKE_TOTAL_COUNT_EN).
// Latency: accept in cycle N, out_valid asserted from cycle N+2 (one COMPARE cycle).
// Backpressure: outputs held in EMIT until out_ready; in_ready only in IDLE.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_potential/in_neuron_id
//        input handshake; timestep_tick decrements refractory counters;
//        out_valid/out_ready/out_potential/out_neuron_id/out_spike/out_addr_err
//        result handshake; spike_total count of emitted spikes (0 when macro off).
module spike_threshold_unit
   import neuron_pkg::*;
#(
   parameter int          NUM_NEURONS      = 30,
   parameter logic [31:0] THRESHOLD        = 32'h41A00000,
   parameter logic [31:0] RESET_POTENTIAL  = 32'h00000000,
   parameter int          REFRACTORY_STEPS = 2
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FP32_W-1:0]      in_potential,
   input  logic [NEURON_ID_W-1:0] in_neuron_id,
   input  logic                   timestep_tick,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FP32_W-1:0]      out_potential,
   output logic [NEURON_ID_W-1:0] out_neuron_id,
   output logic                   out_spike,
   output logic                   out_addr_err,
   output logic [15:0]            spike_total
);

   localparam int CW = (REFRACTORY_STEPS > 0) ? $clog2(REFRACTORY_STEPS + 1) : 1;

   thr_state_t             state;
   logic [FP32_W-1:0]      pot_q;
   logic [NEURON_ID_W-1:0] id_q;
   logic [CW-1:0]          ref_cnt [NUM_NEURONS];

   logic              gt, nan_unused;
   logic              addr_err, busy, spike;
   logic [FP32_W-1:0] result;

   fp32_gt_compare u_cmp (
      .a      (pot_q),
      .b      (THRESHOLD),
      .a_gt_b (gt),
      .is_nan (nan_unused)
   );

   assign in_ready = (state == IDLE);
   assign addr_err = (id_q >= NEURON_ID_W'(NUM_NEURONS));

   // Refractory lookup by address match keeps out-of-range ids off the array.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (id_q == NEURON_ID_W'(i) && ref_cnt[i] != '0) busy = 1'b1;
      end
   end

   // a_gt_b is already 0 for NaN, so the NaN flag needs no further gating.
   assign spike  = !addr_err && !busy && gt;
   assign result = (spike || (busy && !addr_err)) ? RESET_POTENTIAL : pot_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pot_q         <= '0;
         id_q          <= '0;
         out_valid     <= 1'b0;
         out_potential <= '0;
         out_neuron_id <= '0;
         out_spike     <= 1'b0;
         out_addr_err  <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) ref_cnt[i] <= '0;
      end else begin
         // A spike load on the same edge as a tick overrides the decrement.
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (state == COMPARE && spike && id_q == NEURON_ID_W'(i))
               ref_cnt[i] <= CW'(REFRACTORY_STEPS);
            else if (timestep_tick && ref_cnt[i] != '0)
               ref_cnt[i] <= ref_cnt[i] - CW'(1);
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  pot_q <= in_potential;
                  id_q  <= in_neuron_id;
                  state <= COMPARE;
               end
            end
            COMPARE: begin
               out_potential <= result;
               out_neuron_id <= id_q;
               out_spike     <= spike;
               out_addr_err  <= addr_err;
               out_valid     <= 1'b1;
               state         <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPIKE_TOTAL_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_total <= '0;
      end else if (state == EMIT && out_ready && out_spike && spike_total != 16'hFFFF) begin
         spike_total <= spike_total + 16'd1;
      end
   end
`else
   assign spike_total = 16'h0000;
`endif

endmodule
